booth_dadda_mul_pipe: RTL
=========================

Name: booth_dadda_mul_pipe

Overview:
- Parametrised, pipelined radix-4 Booth multiplier with Dadda-tree reduction and a final carry-select adder.
- Successor to the fixed 12-bit combinational Dadda tree. Adds generic operand width, a signed/unsigned mode, valid/ready handshakes on both sides, full-throughput pipelining with backpressure, and an opaque tag carried alongside each operation.
- Sits between the operand-issue logic and the result writeback of the arithmetic datapath.

Parameters:
- WIDTH, 12, operand width in bits; must be even and ≥ 4.
- TAG_W, 4, width of the user tag carried with each operation; must be ≥ 1.
- NPP, derived as WIDTH/2+1, number of Booth partial products. The extra partial product covers the unsigned-mode MSB correction. Not user-overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair and mode are valid.
- in_ready  out  1  block can accept this cycle.
- a_i  in  WIDTH  multiplicand.
- b_i  in  WIDTH  multiplier; Booth-recoded.
- signed_i  in  1  1 = both operands two's complement; 0 = both operands unsigned.
- tag_i  in  TAG_W  opaque ID; returned unchanged with the result.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result this cycle.
- product_o  out  2*WIDTH  full-precision product.
- tag_o  out  TAG_W  tag of the operation presented on product_o.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (asserted asynchronously):
  - all stage valid flags = 0
  - out_valid = 0
  - product_o = 0
  - tag_o = 0
  - in_ready = 1 one cycle after rst_n deasserts.
- Pipeline, three registered stages (S1, S2, S3). Latency from accept to out_valid is 3 cycles when out_ready is held high.
  - S1: Booth encode b_i (digits from overlapping triplets, b[-1]=0).
    - Extend b by 2 bits: sign-extend when signed_i=1, zero-extend when signed_i=0.
    - Generate NPP partial products in the set {0, ±A, ±2A}.
    - Negation uses the one's complement plus a correction bit inserted at the PP LSB position.
    - Sign extension is replaced by the constant-1 sign-encoding trick (inverted sign bit plus leading 1s).
    - Register the partial-product matrix, mode, and tag.
  - S2: Dadda reduction of the matrix down to height 2.
    - Stage heights follow the sequence 2, 3, 4, 6, 9, …, truncated at NPP.
    - Uses full and half adders only.
    - Register the two rows and the tag.
  - S3: two-operand carry-select addition, truncated to 2*WIDTH bits; register into product_o and tag_o.
- Arithmetic: product_o equals the exact a×b under the selected mode, modulo 2^(2*WIDTH). The final carry-out and any constant-1 overflow from the sign encoding are discarded.
- Handshake (standard valid/ready):
  - Transfer on the input side when in_valid & in_ready. Transfer on the output side when out_valid & out_ready.
  - Stage k advances when it is empty or stage k+1 advances. S3 advances when out_ready=1 or S3 is empty.
  - in_ready = !S1.valid | S1 advances. This is a combinational path from out_ready.
  - Throughput: one operation per cycle with no bubbles while out_ready=1.
- Stall:
  - While out_valid & !out_ready, product_o and tag_o hold stable.
  - Internal stages continue to fill until all three are occupied; then in_ready=0.
  - At most 3 operations are in flight.
- Simultaneous events:
  - Accept and retire in the same cycle on a full pipeline: allowed, occupancy unchanged.
  - in_valid while in_ready=0: inputs are ignored; the source must hold them.
- Mode per operation: signed_i travels with its operation, so mixed modes can be back to back.
- Reset mid-operation: all in-flight operations are dropped with no partial output, and out_valid falls immediately.
- Inputs are don't-care when in_valid=0. X on unaccepted inputs must not propagate to the outputs.

Test Plan (WIDTH=12):
- Signed, a=0x800, b=0x800, tag 3, out_ready=1 → after 3 cycles out_valid=1, product_o=0x400000, tag_o=3.
- Unsigned, a=0xFFF, b=0xFFF → product_o=0xFFE001; the same operands in signed mode → product_o=0x000001.
- Signed, a=0x7FF, b=0x800 → product_o=0xC00800. Then issue a=0, b=0x5A5 → product_o=0.
- Back-to-back stream of 8 operations with alternating mode, out_ready=1 → 8 consecutive out_valid cycles in order, tags 0–7, all products matching the reference model.
- out_ready=0 while issuing continuously → exactly 3 accepts, then in_ready=0 with product_o stable. Raise out_ready → results drain in order, and in_ready=1 in the same cycle.
- Assert rst_n=0 with 2 operations in flight → out_valid=0 and product_o=0 asynchronously. After release, no stale result appears. Follow with 2000 random operands in both modes checked against a behavioural model.

Source files
------------

// File: rtl/booth_dadda_mul_pipe.sv
// Pipelined radix-4 Booth multiplier: S1 Booth encode, S2 Dadda reduction, S3 carry-select add.
// Valid/ready on both sides with full-throughput backpressure; a user tag travels with each operation.
module booth_dadda_mul_pipe #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 signed_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product_o,
  output logic [TAG_W-1:0]     tag_o
);

  localparam int unsigned NPP  = WIDTH / 2 + 1;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned RW   = WIDTH + 2;
  localparam int unsigned MAXH = NPP + 2;
  localparam int unsigned NDS  = 12;
  localparam int unsigned BLK  = 4;

  // Folded constant of the sign-encoding trick: each row contributes -2^(WIDTH+1+2i).
  function automatic logic [PW-1:0] sign_const();
    logic [PW-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < NPP; i++) begin
      if (WIDTH + 1 + 2 * i < PW) begin
        k = k - ({{(PW-1){1'b0}}, 1'b1} << (WIDTH + 1 + 2 * i));
      end
    end
    return k;
  endfunction

  localparam logic [PW-1:0] SIGN_K = sign_const();

  // Column-wise Dadda reduction; targets come from the 2,3,4,6,9,... sequence below MAXH.
  function automatic logic [1:0][PW-1:0] dadda_reduce(
    input logic [NPP-1:0][RW-1:0] pp,
    input logic [NPP-1:0]         neg
  );
    logic               col  [PW][MAXH];
    logic               nxt  [PW][MAXH];
    int unsigned        h    [PW];
    int unsigned        nh   [PW];
    int unsigned        dseq [NDS];
    int unsigned        c, k, tot, d;
    logic               cy;
    logic [1:0][PW-1:0] rows;

    for (int unsigned ci = 0; ci < PW; ci++) begin
      h[ci]  = 0;
      nh[ci] = 0;
      for (int unsigned j = 0; j < MAXH; j++) begin
        col[ci][j] = 1'b0;
        nxt[ci][j] = 1'b0;
      end
    end

    for (int unsigned i = 0; i < NPP; i++) begin
      for (int unsigned j = 0; j < RW; j++) begin
        if (2 * i + j < PW) begin
          c = 2 * i + j;
          col[c][h[c]] = pp[i][j];
          h[c]++;
        end
      end
      col[2*i][h[2*i]] = neg[i];
      h[2*i]++;
    end

    for (int unsigned ci = 0; ci < PW; ci++) begin
      if (SIGN_K[ci]) begin
        col[ci][h[ci]] = 1'b1;
        h[ci]++;
      end
    end

    dseq[0] = 2;
    for (int unsigned s = 1; s < NDS; s++) dseq[s] = dseq[s-1] * 3 / 2;

    cy = 1'b0;
    for (int unsigned s = NDS; s > 0; s--) begin
      d = dseq[s-1];
      if (d < MAXH) begin
        for (int unsigned ci = 0; ci < PW; ci++) begin
          nh[ci] = 0;
          for (int unsigned j = 0; j < MAXH; j++) nxt[ci][j] = 1'b0;
        end
        for (int unsigned ci = 0; ci < PW; ci++) begin
          k = 0;
          // Carries from column ci-1 already sit in nxt[ci] and count toward the target.
          for (int unsigned it = 0; it < MAXH; it++) begin
            tot = h[ci] - k + nh[ci];
            if (tot > d && h[ci] - k >= 2) begin
              if (tot == d + 1 || h[ci] - k == 2) begin
                nxt[ci][nh[ci]] = col[ci][k] ^ col[ci][k+1];
                cy = col[ci][k] & col[ci][k+1];
                k  = k + 2;
              end else begin
                nxt[ci][nh[ci]] = col[ci][k] ^ col[ci][k+1] ^ col[ci][k+2];
                cy = (col[ci][k] & col[ci][k+1]) | (col[ci][k+2] & (col[ci][k] ^ col[ci][k+1]));
                k  = k + 3;
              end
              nh[ci]++;
              if (ci + 1 < PW) begin
                nxt[ci+1][nh[ci+1]] = cy;
                nh[ci+1]++;
              end
            end
          end
          for (int unsigned j = 0; j < MAXH; j++) begin
            if (j >= k && j < h[ci]) begin
              nxt[ci][nh[ci]] = col[ci][j];
              nh[ci]++;
            end
          end
        end
        col = nxt;
        h   = nh;
      end
    end

    rows = '0;
    for (int unsigned ci = 0; ci < PW; ci++) begin
      rows[0][ci] = (h[ci] > 0) ? col[ci][0] : 1'b0;
      rows[1][ci] = (h[ci] > 1) ? col[ci][1] : 1'b0;
    end
    return rows;
  endfunction

  function automatic logic [PW-1:0] csel_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW-1:0] s;
    logic [BLK:0]  s0, s1;
    logic          cin;
    s   = '0;
    cin = 1'b0;
    for (int unsigned blk = 0; blk < PW / BLK; blk++) begin
      s0  = {1'b0, x[blk*BLK +: BLK]} + {1'b0, y[blk*BLK +: BLK]};
      s1  = {1'b0, x[blk*BLK +: BLK]} + {1'b0, y[blk*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
      s[blk*BLK +: BLK] = cin ? s1[BLK-1:0] : s0[BLK-1:0];
      cin = cin ? s1[BLK] : s0[BLK];
    end
    return s;
  endfunction

  logic                    ready_en;
  logic                    v1, v2, v3;
  logic                    adv1, adv2, adv3;
  logic                    accept;

  logic [RW-1:0]           a_ext;
  logic [RW:0]             b_trip;
  logic [2:0]              trip;
  logic                    one, two;
  logic [RW-1:0]           mag, row;
  logic [NPP-1:0][RW-1:0]  pp_d, pp1;
  logic [NPP-1:0]          neg_d, neg1;
  logic [TAG_W-1:0]        tag1, tag2;
  logic [1:0][PW-1:0]      rows_d, rows2;
  logic [PW-1:0]           sum_d;

  always_comb begin
    adv3     = !v3 || out_ready;
    adv2     = !v2 || adv3;
    adv1     = !v1 || adv2;
    in_ready = ready_en && adv1;
    accept   = in_valid && in_ready;
  end

  assign out_valid = v3;

  // S1: Booth digits from overlapping triplets of b extended by two bits, b[-1] = 0.
  always_comb begin
    a_ext  = signed_i ? {{2{a_i[WIDTH-1]}}, a_i} : {2'b00, a_i};
    b_trip = signed_i ? {{2{b_i[WIDTH-1]}}, b_i, 1'b0} : {2'b00, b_i, 1'b0};
    trip   = '0;
    one    = 1'b0;
    two    = 1'b0;
    mag    = '0;
    row    = '0;
    pp_d   = '0;
    neg_d  = '0;
    for (int unsigned i = 0; i < NPP; i++) begin
      trip     = b_trip[2*i +: 3];
      one      = trip[1] ^ trip[0];
      two      = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
      mag      = one ? a_ext : (two ? {a_ext[RW-2:0], 1'b0} : '0);
      row      = trip[2] ? ~mag : mag;
      pp_d[i]  = {~row[RW-1], row[RW-2:0]};
      neg_d[i] = trip[2];
    end
  end

  always_comb rows_d = dadda_reduce(pp1, neg1);
  always_comb sum_d  = csel_add(rows2[0], rows2[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      v1       <= 1'b0;
      pp1      <= '0;
      neg1     <= '0;
      tag1     <= '0;
    end else begin
      ready_en <= 1'b1;
      if (adv1) v1 <= accept;
      if (accept) begin
        pp1  <= pp_d;
        neg1 <= neg_d;
        tag1 <= tag_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      rows2 <= '0;
      tag2  <= '0;
    end else begin
      if (adv2) v2 <= v1;
      if (adv2 && v1) begin
        rows2 <= rows_d;
        tag2  <= tag1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3        <= 1'b0;
      product_o <= '0;
      tag_o     <= '0;
    end else begin
      if (adv3) v3 <= v2;
      if (adv3 && v2) begin
        product_o <= sum_d;
        tag_o     <= tag2;
      end
    end
  end

endmodule
